lab72_soc_key_edge_pio: RTL and testbench

Parametrised Avalon-MM input port for push-buttons and switches, for the lab SoC fabric alongside the other PIO slaves. It samples up to 32 asynchronous inputs through a two-flop synchroniser and latches edges per bit into a sticky edge-capture register. It drives a maskable level interrupt to the Nios II. Register map and one-cycle read latency match the standard PIO slaves, so existing driver code for them reads this block's data register unchanged.

---
 rtl/lab72_soc_key_edge_pio.sv | 128 ++++++++++++
 tb/tb_lab72_soc_key_edge_pio.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab72_soc_key_edge_pio.sv
// Avalon-MM key/switch PIO: synchronised inputs, sticky edge capture, maskable irq.
// Optional per-bit debounce filter is compiled in with KEY_PIO_DEBOUNCE_EN.
module lab72_soc_key_edge_pio #(
    parameter int WIDTH           = 2,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_bits;

    assign wr_en       = chipselect & ~write_n;
    assign unused_bits = &{1'b0, writedata, (DEBOUNCE_CYCLES != 0)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            prev  <= IDLE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= level;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // A bit is accepted once sync2 has disagreed with level for the full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= IDLE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= IDLE;
        end else begin
            level <= sync2;
        end
    end
`endif

    always_comb begin
        detect = '0;
        case (EDGE_TYPE)
            0:       detect = level & ~prev;
            1:       detect = ~level & prev;
            default: detect = level ^ prev;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (wr_en && address == 2'd3) begin
            clr_mask = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = level;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    // A fresh detect outranks a simultaneous write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            edge_cap <= detect | (edge_cap & ~clr_mask);
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            irq      <= |(edge_cap & irq_mask);
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_lab72_soc_key_edge_pio.sv
// Bench for lab72_soc_key_edge_pio: cycle model of the register view plus
// directed checks of edge, mask, W1C, reset and (if compiled) debounce timing.
module tb_lab72_soc_key_edge_pio;

    localparam int W    = 2;
    localparam int ET   = 1;
    localparam bit IDLE = 1'b1;
    localparam int D    = 8;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int EXTRA = D - 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int HL = D + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = 2'b11;
    logic         irq;

    always #5 clk = ~clk;

    lab72_soc_key_edge_pio #(
        .WIDTH(W),
        .EDGE_TYPE(ET),
        .IDLE_LEVEL(IDLE),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a history of raw samples, the filtered level derived from it,
    // and the architectural registers as the bus sees them.
    logic [W-1:0] hist [HL];
    logic [W-1:0] lvl_m;
    logic [W-1:0] prv_m;
    logic [W-1:0] cap_m;
    logic [W-1:0] mask_m;
    logic         irq_m;
    logic [31:0]  rd_m;

    function automatic logic [W-1:0] det_f(input logic [W-1:0] l,
                                           input logic [W-1:0] p);
        case (ET)
            0:       return l & ~p;
            1:       return ~l & p;
            default: return l ^ p;
        endcase
    endfunction

    function automatic logic [W-1:0] lvl_next();
`ifdef KEY_PIO_DEBOUNCE_EN
        logic [W-1:0] r;
        r = lvl_m;
        for (int b = 0; b < W; b++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 1; j <= D; j++) begin
                if (hist[j][b] == lvl_m[b]) flip = 1'b0;
            end
            if (flip) r[b] = ~lvl_m[b];
        end
        return r;
`else
        return hist[1];
`endif
    endfunction

    function automatic logic [31:0] reg_view(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, lvl_m};
            2'd2:    return {30'd0, mask_m};
            2'd3:    return {30'd0, cap_m};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HL; i++) hist[i] <= {W{IDLE}};
            lvl_m  <= {W{IDLE}};
            prv_m  <= {W{IDLE}};
            cap_m  <= '0;
            mask_m <= '0;
            irq_m  <= 1'b0;
            rd_m   <= '0;
        end else begin
            hist[0] <= in_port;
            for (int i = 1; i < HL; i++) hist[i] <= hist[i-1];
            lvl_m <= lvl_next();
            prv_m <= lvl_m;
            cap_m <= det_f(lvl_m, prv_m) |
                     (cap_m & ~((chipselect && !write_n && address == 2'd3)
                                ? writedata[W-1:0] : {W{1'b0}}));
            if (chipselect && !write_n && address == 2'd2)
                mask_m <= writedata[W-1:0];
            irq_m <= |(cap_m & mask_m);
            rd_m  <= reg_view(address);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_readdata", readdata, rd_m);
        chk("cyc_irq", {31'd0, irq}, {31'd0, irq_m});
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                      input string nm);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        chk(nm, readdata, exp);
    endtask

    initial begin
        reset   = 1'b1;
        in_port = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        rd(2'd0, 32'h3, "idle_data");
        rd(2'd3, 32'h0, "idle_edgecap");
        chk("idle_irq", {31'd0, irq}, 32'd0);
        rd(2'd1, 32'h0, "reserved");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0, "reserved_write");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h3, "mask_upper_bits");
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "mask_readback");

        // falling edge on bit 0, enabled
        @(negedge clk);
        address = 2'd3;
        in_port = 2'b10;
        @(posedge clk);
        repeat (3 + EXTRA) @(posedge clk);
        #1;
        chk("irq_before_k4", {31'd0, irq}, 32'd0);
        chk("cap_read_k3", readdata, 32'h0);
        @(posedge clk);
        #1;
        chk("irq_at_k4", {31'd0, irq}, 32'd1);
        chk("cap_read_k4", readdata, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_hold_at_clear", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        chk("irq_after_clear", {31'd0, irq}, 32'd0);

        // masked edge on bit 1, then unmask
        @(negedge clk);
        in_port = 2'b00;
        repeat (6 + EXTRA) @(posedge clk);
        rd(2'd3, 32'h2, "cap_bit1");
        chk("irq_masked", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h3);
        chk("irq_mask_same", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        chk("irq_unmasked", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_all_clear", {31'd0, irq}, 32'd0);
        rd(2'd3, 32'h0, "cap_all_clear");

        // rising edges ignored; then W1C colliding with a new detect
        @(negedge clk);
        in_port = 2'b11;
        repeat (6 + EXTRA) @(posedge clk);
        rd(2'd3, 32'h0, "rise_ignored");
        @(negedge clk);
        in_port = 2'b10;
        @(posedge clk);
        repeat (3 + EXTRA) @(negedge clk);
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h1;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        @(posedge clk);
        #1;
        chk("w1c_vs_detect", readdata, 32'h1);
        chk("w1c_vs_detect_irq", {31'd0, irq}, 32'd1);

`ifdef KEY_PIO_DEBOUNCE_EN
        @(negedge clk);
        in_port = 2'b11;
        repeat (15) @(posedge clk);
        wr(2'd3, 32'h3);
        @(negedge clk);
        in_port = 2'b10;
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_port = 2'b11;
        repeat (15) @(posedge clk);
        rd(2'd0, 32'h3, "glitch_data");
        rd(2'd3, 32'h0, "glitch_cap");
        @(negedge clk);
        address = 2'd0;
        in_port = 2'b10;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        chk("db_data_k9", readdata, 32'h3);
        @(posedge clk);
        #1;
        chk("db_data_k10", readdata, 32'h2);
        repeat (3) @(posedge clk);
        rd(2'd3, 32'h1, "db_cap");
`endif

        // reset mid-operation with both flags pending and enabled
        @(negedge clk);
        in_port = 2'b00;
        repeat (6 + EXTRA) @(posedge clk);
        @(negedge clk);
        in_port = 2'b11;
        repeat (6 + EXTRA) @(posedge clk);
        rd(2'd3, 32'h3, "pre_reset_cap");
        chk("pre_reset_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_reset_irq", {31'd0, irq}, 32'd0);
        chk("mid_reset_readdata", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(2'd2, 32'h0, "post_reset_mask");
        rd(2'd3, 32'h0, "post_reset_cap");
        repeat (10 + EXTRA) @(posedge clk);
        rd(2'd3, 32'h0, "no_spurious_edge");
        rd(2'd0, 32'h3, "post_reset_data");
        chk("post_reset_irq", {31'd0, irq}, 32'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
